// File: rtl/elastic_pipe.sv
// N-stage elastic pipeline: per-stage valid/ready flow control with hold and prefix flush.
// Payload transforms live outside; this block owns occupancy, movement, kill and counters.
module elastic_pipe #(
   parameter int unsigned STAGES = 5,
   parameter int unsigned WIDTH  = 64,
   parameter int unsigned CNT_W  = 32
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [WIDTH-1:0]              in_data,
   input  logic [(STAGES-1)*WIDTH-1:0]   nxt_data,
   input  logic [STAGES-1:0]             hold,
   input  logic [STAGES-1:0]             flush,
   output logic [STAGES-1:0]             stage_valid,
   output logic [STAGES*WIDTH-1:0]       stage_data,
   output logic                          out_valid,
   output logic [WIDTH-1:0]              out_data,
   input  logic                          out_ready,
   output logic [CNT_W-1:0]              retire_cnt,
   output logic [CNT_W-1:0]              stall_cnt
);

   localparam int unsigned L = STAGES - 1;

   logic [STAGES-1:0] v_q;
   logic [WIDTH-1:0]  data_q [STAGES];
   logic [STAGES:0]   rdy_c;
   logic [STAGES-1:0] fire_c;
   logic              in_fire_c;
   logic [CNT_W-1:0]  retire_q;
   logic [CNT_W-1:0]  stall_q;

   // Ready ripples from the commit side back toward fetch; flush never gates it.
   always_comb begin
      rdy_c  = '0;
      fire_c = '0;
      rdy_c[STAGES] = out_ready;
      for (int i = int'(L); i >= 0; i--) begin
         rdy_c[i]  = !v_q[i] | (!hold[i] & rdy_c[i+1]);
         fire_c[i] = v_q[i] & !hold[i] & !flush[i] & rdy_c[i+1];
      end
   end

   assign in_ready  = rst & rdy_c[0] & !flush[0];
   assign out_valid = rst & v_q[L] & !hold[L] & !flush[L];
   assign in_fire_c = in_valid & in_ready;

   for (genvar g = 0; g < int'(STAGES); g++) begin : g_stage
      logic             arrive_c;
      logic [WIDTH-1:0] arr_data_c;
      logic             v_r;
      logic [WIDTH-1:0] d_r;

      if (g == 0) begin : g_head
         assign arrive_c   = in_fire_c;
         assign arr_data_c = in_data;
      end else begin : g_body
         assign arrive_c   = fire_c[g-1];
         assign arr_data_c = nxt_data[(g-1)*WIDTH +: WIDTH];
      end

      // Flush beats arrival beats departure; otherwise the item stays put.
      always_ff @(posedge clk) begin
         if (!rst) begin
            v_r <= 1'b0;
            d_r <= '0;
         end else if (flush[g]) begin
            v_r <= 1'b0;
         end else if (arrive_c) begin
            v_r <= 1'b1;
            d_r <= arr_data_c;
         end else if (fire_c[g]) begin
            v_r <= 1'b0;
         end
      end

      assign v_q[g]                        = v_r;
      assign data_q[g]                     = d_r;
      assign stage_data[g*WIDTH +: WIDTH]  = d_r;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         retire_q <= '0;
         stall_q  <= '0;
      end else begin
         if (out_valid & out_ready)
            retire_q <= retire_q + CNT_W'(1);
         if (in_valid & !in_ready)
            stall_q <= stall_q + CNT_W'(1);
      end
   end

   assign stage_valid = v_q;
   assign out_data    = data_q[L];
   assign retire_cnt  = retire_q;
   assign stall_cnt   = stall_q;

endmodule

// File: tb/tb_elastic_pipe.sv
// Bench for elastic_pipe: directed table, hand-written corner sequences, and random traffic
// against an item-tracking reference model with an in-order retire scoreboard.
module tb_elastic_pipe;

   localparam int unsigned STAGES = 5;
   localparam int unsigned WIDTH  = 64;
   localparam int unsigned CNT_W  = 32;
   localparam int          L      = 4;

   logic                        clk = 1'b0;
   logic                        rst;
   logic                        in_valid;
   logic                        in_ready;
   logic [WIDTH-1:0]            in_data;
   logic [(STAGES-1)*WIDTH-1:0] nxt_data;
   logic [STAGES-1:0]           hold;
   logic [STAGES-1:0]           flush;
   logic [STAGES-1:0]           stage_valid;
   logic [STAGES*WIDTH-1:0]     stage_data;
   logic                        out_valid;
   logic [WIDTH-1:0]            out_data;
   logic                        out_ready;
   logic [CNT_W-1:0]            retire_cnt;
   logic [CNT_W-1:0]            stall_cnt;

   elastic_pipe #(.STAGES(STAGES), .WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .nxt_data(nxt_data), .hold(hold), .flush(flush), .stage_valid(stage_valid),
      .stage_data(stage_data), .out_valid(out_valid), .out_data(out_data),
      .out_ready(out_ready), .retire_cnt(retire_cnt), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   // External per-stage logic: each hop adds one to the payload.
   always_comb begin
      nxt_data = '0;
      for (int k = 1; k <= L; k++)
         nxt_data[(k-1)*WIDTH +: WIDTH] = stage_data[(k-1)*WIDTH +: WIDTH] + 64'd1;
   end

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: which slots hold an item, and the value it entered with.
   logic [4:0]  m_v;
   logic [63:0] m_base [5];
   logic [31:0] m_ret, m_stall;
   logic [63:0] sb [$];
   logic [5:0]  sp;
   logic        e_in_ready, e_out_valid;

   task automatic settle();
      @(negedge clk);
      assert ((flush & (flush + 5'd1)) == 5'd0) else $error("illegal flush vector %b", flush);
      sp[5] = out_ready;
      for (int i = L; i >= 0; i--)
         sp[i] = !m_v[i] | (!hold[i] & sp[i+1]);
      e_in_ready  = rst & sp[0] & !flush[0];
      e_out_valid = rst & m_v[L] & !hold[L] & !flush[L];
      chk("in_ready", 64'(in_ready), 64'(e_in_ready));
      chk("out_valid", 64'(out_valid), 64'(e_out_valid));
      if (rst) begin
         chk("stage_valid", 64'(stage_valid), 64'(m_v));
         for (int i = 0; i <= L; i++)
            if (m_v[i])
               chk("stage_data", stage_data[i*WIDTH +: WIDTH], m_base[i] + 64'(i));
         chk("retire_cnt", 64'(retire_cnt), 64'(m_ret));
         chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL retire_order: got %0h expected nothing in flight", out_data);
            end else begin
               chk("retire_order", out_data, sb[0] + 64'd4);
            end
         end
      end
   endtask

   task automatic edge_commit();
      logic [4:0]  nv;
      logic [63:0] nb [5];
      @(posedge clk);
      if (!rst) begin
         m_v = '0;
         m_ret = '0;
         m_stall = '0;
         sb.delete();
      end else begin
         nv = '0;
         for (int i = 0; i <= L; i++) nb[i] = m_base[i];
         if (in_valid && !e_in_ready) m_stall++;
         if (e_out_valid && out_ready) begin
            m_ret++;
            void'(sb.pop_front());
         end
         for (int i = L; i >= 0; i--) begin
            if (m_v[i]) begin
               if (flush[i]) begin
                  void'(sb.pop_back());
               end else if (!hold[i] && sp[i+1]) begin
                  if (i < L) begin
                     nv[i+1] = 1'b1;
                     nb[i+1] = m_base[i];
                  end
               end else begin
                  nv[i] = 1'b1;
                  nb[i] = m_base[i];
               end
            end
         end
         if (in_valid && e_in_ready) begin
            nv[0] = 1'b1;
            nb[0] = in_data;
            sb.push_back(in_data);
         end
         m_v = nv;
         for (int i = 0; i <= L; i++) m_base[i] = nb[i];
      end
      #1;
   endtask

   task automatic tick();
      settle();
      edge_commit();
   endtask

   typedef struct {
      logic        iv;
      logic [63:0] d;
      logic [4:0]  exp_sv;
      logic        exp_ir;
      logic        exp_ov;
      logic [63:0] exp_od;
      logic [31:0] exp_ret;
   } row_t;

   row_t tbl [9];
   logic pending;

   initial begin
      tbl[0] = '{1'b1, 64'h10, 5'b00000, 1'b1, 1'b0, 64'h0,  32'd0};
      tbl[1] = '{1'b1, 64'h20, 5'b00001, 1'b1, 1'b0, 64'h0,  32'd0};
      tbl[2] = '{1'b1, 64'h30, 5'b00011, 1'b1, 1'b0, 64'h0,  32'd0};
      tbl[3] = '{1'b0, 64'h0,  5'b00111, 1'b1, 1'b0, 64'h0,  32'd0};
      tbl[4] = '{1'b0, 64'h0,  5'b01110, 1'b1, 1'b0, 64'h0,  32'd0};
      tbl[5] = '{1'b0, 64'h0,  5'b11100, 1'b1, 1'b1, 64'h14, 32'd0};
      tbl[6] = '{1'b0, 64'h0,  5'b11000, 1'b1, 1'b1, 64'h24, 32'd1};
      tbl[7] = '{1'b0, 64'h0,  5'b10000, 1'b1, 1'b1, 64'h34, 32'd2};
      tbl[8] = '{1'b0, 64'h0,  5'b00000, 1'b1, 1'b0, 64'h0,  32'd3};

      m_v = '0; m_ret = '0; m_stall = '0;
      for (int i = 0; i <= L; i++) m_base[i] = '0;
      rst = 1'b0; in_valid = 1'b0; in_data = '0; hold = '0; flush = '0; out_ready = 1'b1;
      tick();
      tick();
      rst = 1'b1;
      settle();
      chk("reset_sv", 64'(stage_valid), 64'd0);
      chk("reset_retire", 64'(retire_cnt), 64'd0);
      chk("reset_stall", 64'(stall_cnt), 64'd0);
      edge_commit();

      // Streaming table
      for (int r = 0; r < 9; r++) begin
         in_valid = tbl[r].iv;
         in_data  = tbl[r].d;
         settle();
         chk("tbl_sv", 64'(stage_valid), 64'(tbl[r].exp_sv));
         chk("tbl_in_ready", 64'(in_ready), 64'(tbl[r].exp_ir));
         chk("tbl_out_valid", 64'(out_valid), 64'(tbl[r].exp_ov));
         if (tbl[r].exp_ov) chk("tbl_out_data", out_data, tbl[r].exp_od);
         chk("tbl_retire", 64'(retire_cnt), 64'(tbl[r].exp_ret));
         edge_commit();
      end

      // Hold in the middle stage
      out_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         in_valid = 1'b1;
         in_data  = 64'h100 * 64'(k + 1);
         settle();
         chk("fill_ready", 64'(in_ready), 64'd1);
         edge_commit();
      end
      in_data = 64'h600; out_ready = 1'b1; hold = 5'b00100;
      for (int k = 0; k < 3; k++) begin
         settle();
         chk("hold_in_ready", 64'(in_ready), 64'd0);
         edge_commit();
      end
      hold = '0;
      settle();
      chk("hold_sv", 64'(stage_valid), 64'b00111);
      chk("hold_stall", 64'(stall_cnt), 64'd3);
      chk("hold_retire", 64'(retire_cnt), 64'd5);
      edge_commit();
      in_valid = 1'b0;
      for (int k = 0; k < 10; k++) tick();
      settle();
      chk("hold_drain_retire", 64'(retire_cnt), 64'd9);
      chk("hold_drain_sv", 64'(stage_valid), 64'd0);
      edge_commit();

      // Backpressure with a full pipe
      out_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         in_valid = 1'b1;
         in_data  = 64'h1000 + 64'(k);
         tick();
      end
      in_data = 64'h700;
      for (int k = 0; k < 3; k++) begin
         settle();
         chk("bp_sv", 64'(stage_valid), 64'b11111);
         chk("bp_in_ready", 64'(in_ready), 64'd0);
         chk("bp_out_valid", 64'(out_valid), 64'd1);
         edge_commit();
      end
      out_ready = 1'b1;
      settle();
      chk("bp_release_ready", 64'(in_ready), 64'd1);
      edge_commit();

      // Prefix flush on a full pipe
      in_valid = 1'b0; flush = 5'b00111;
      settle();
      chk("flush_sv_before", 64'(stage_valid), 64'b11111);
      chk("flush_in_ready", 64'(in_ready), 64'd0);
      edge_commit();
      flush = '0;
      settle();
      chk("flush_sv_after", 64'(stage_valid), 64'b10000);
      edge_commit();
      for (int k = 0; k < 3; k++) tick();
      settle();
      chk("flush_survivors", 64'(retire_cnt), 64'd12);
      edge_commit();

      // Push coinciding with flush of stage 0
      in_valid = 1'b1; in_data = 64'h800; flush = 5'b00001;
      settle();
      chk("pushflush_ready", 64'(in_ready), 64'd0);
      edge_commit();
      in_valid = 1'b0; flush = '0;
      settle();
      chk("pushflush_sv", 64'(stage_valid), 64'd0);
      edge_commit();

      // Reset in the middle of a stream
      for (int k = 0; k < 3; k++) begin
         in_valid = 1'b1;
         in_data  = 64'h900 + 64'h100 * 64'(k);
         tick();
      end
      in_valid = 1'b0; rst = 1'b0;
      settle();
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      edge_commit();
      rst = 1'b1;
      settle();
      chk("rst_sv", 64'(stage_valid), 64'd0);
      chk("rst_retire", 64'(retire_cnt), 64'd0);
      chk("rst_stall", 64'(stall_cnt), 64'd0);
      edge_commit();
      in_valid = 1'b1; in_data = 64'hC00;
      tick();
      in_valid = 1'b0;
      for (int k = 0; k < 4; k++) tick();
      settle();
      chk("rst_first_out_valid", 64'(out_valid), 64'd1);
      chk("rst_first_out_data", out_data, 64'hC04);
      edge_commit();

      // Random traffic against the model
      pending = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         if (!pending) begin
            in_valid = ($urandom_range(0, 2) != 0);
            in_data  = {$urandom, $urandom};
         end
         for (int i = 0; i <= L; i++) hold[i] = ($urandom_range(0, 4) == 0);
         out_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 29) == 0)
            flush = 5'((6'd1 << $urandom_range(1, 5)) - 6'd1);
         else
            flush = '0;
         rst = ($urandom_range(0, 199) != 0);
         tick();
         pending = rst && in_valid && !e_in_ready;
      end

      rst = 1'b1; in_valid = 1'b0; hold = '0; flush = '0; out_ready = 1'b1;
      for (int k = 0; k < 10; k++) tick();
      settle();
      chk("final_empty", 64'(stage_valid), 64'd0);
      edge_commit();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/elastic_pipe.md
Name: elastic_pipe

Overview:
- Generic N-stage pipeline register chain with per-stage valid/ready flow control, per-stage hold and per-stage flush.
- Replaces the single global-stall "all stages advance or none" scheme in the core top. A stall in one stage only backs up the stages behind it, and bubbles ahead of it still drain.
- External per-stage logic computes each stage's next payload from the previous stage's registered payload. This block owns only valid, occupancy, movement, kill and performance counters.

Parameters:
STAGES, 5, number of pipeline stages (>=2); stage 0 is youngest (fetch side), stage STAGES-1 is oldest (commit side)
WIDTH, 64, payload bits per stage
CNT_W, 32, width of performance counters

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, synchronous, active-low (0 = reset)
in_valid  in  1  new item offered to stage 0
in_ready  out  1  stage 0 accepts this cycle
in_data  in  WIDTH  payload loaded into stage 0 on accept
nxt_data  in  (STAGES-1)*WIDTH  slice k-1 (k=1..STAGES-1) = payload stage k loads when stage k-1 moves into it
hold  in  STAGES  bit i: stage i's item is not finished (e.g. memory wait); it stays put
flush  in  STAGES  bit i: kill stage i's item this cycle
stage_valid  out  STAGES  registered valid per stage
stage_data  out  STAGES*WIDTH  registered payload per stage (slice i = stage i)
out_valid  out  1  oldest stage presents a finished item
out_data  out  WIDTH  = stage_data slice STAGES-1
out_ready  in  1  consumer takes the item
retire_cnt  out  CNT_W  items retired
stall_cnt  out  CNT_W  cycles with in_valid=1 and in_ready=0

Behaviour:
- Let L = STAGES-1 and v[i] = stage_valid[i].
- rdy[L+1] = out_ready.
- rdy[i] = !v[i] | (!hold[i] & rdy[i+1]). This is a combinational chain with no flush term.
- fire[i] = v[i] & !hold[i] & !flush[i] & rdy[i+1].
- in_fire = in_valid & in_ready.
- in_ready = rst & rdy[0] & !flush[0].
- out_valid = rst & v[L] & !hold[L] & !flush[L].
- Handshake: out_valid/out_ready and in_valid/in_ready transfer only when both are high.
  - Producer must hold in_valid/in_data stable until accepted.
  - out_valid may deassert without a transfer when hold or flush rises.
- Next-state per stage i, in priority order:
  1. flush[i]: v[i] <= 0.
  2. An item arrives (in_fire for i=0, fire[i-1] for i>0): v[i] <= 1, data <= in_data or nxt_data slice.
  3. fire[i]: v[i] <= 0.
  4. Otherwise: hold.
- An item is never duplicated or lost except by flush.
- Flush legality: flush must be a contiguous prefix. flush[i]=1 implies flush[j]=1 for all j<i (younger stages).
  - Consequence: a flushed stage never has an item pushed into it from a live stage.
  - A non-prefix vector is illegal. The RTL still clears every set stage, and the bench asserts on it.
- Latency: accept at cycle t → stage 0 at t+1 → stage L at t+STAGES with no holds. out_valid is high in that cycle.
- Throughput: 1 item/cycle sustained when hold=0 and out_ready=1.
- Full pipeline with out_ready=1 and no holds: in_ready=1, and all stages shift together in the same cycle.
- Hold in stage i:
  - Stages >i keep draining.
  - Stages <i fill bubbles, then stall.
  - The first empty stage behind i still accepts.
- Counters:
  - retire_cnt += 1 on out_valid & out_ready.
  - stall_cnt += 1 when in_valid & !in_ready and rst=1.
  - Both counters wrap modulo 2^CNT_W.
- Reset (rst=0 at a rising edge):
  - All stage_valid cleared; all stage_data and both counters cleared to 0.
  - While rst=0: in_ready=0 and out_valid=0.
  - Reset asserted mid-operation discards all in-flight items at that edge.
- stage_valid and stage_data are registered outputs, usable for forwarding.

Test Plan:
- Bench model: nxt_data slice k-1 = stage_data slice k-1 + 1. STAGES=5, WIDTH=64.
- Streaming: push 0x10,0x20,0x30 back-to-back, out_ready=1 → out_data 0x14,0x24,0x34 on cycles t+5,t+6,t+7; retire_cnt=3.
- Hold mid-pipe: fill 5 items, set hold[2] for 3 cycles → stages 3,4 drain 2 items; stages 0..2 freeze; in_ready=0 for 3 cycles; stall_cnt=3 with in_valid=1; release → remaining items retire in order, no loss.
- Backpressure: out_ready=0 with pipeline full → stage_valid=5'b11111, in_ready=0, out_valid=1 steady; set out_ready=1 and in_valid=1 → full-rate shift, in_ready=1 same cycle.
- Prefix flush: full pipe, flush=5'b00111 for one cycle → stage_valid next cycle: stages 0..2 = 0, stages 3,4 shifted; in_ready=0 during the flush cycle; retire_cnt counts only the 2 survivors.
- Simultaneous push and flush: in_valid=1 with flush[0]=1 → no accept, stage 0 empty next cycle.
- Reset mid-stream: drive rst=0 for one edge with 3 items in flight → all stage_valid=0, counters=0; in_ready=0 and out_valid=0 during reset; the first push after reset retires 5 cycles later.
